swervolf_gpio_io: RTL
=====================

# swervolf_gpio_io

Parametrised board-I/O front end between FPGA pins and the `swervolf_core` GPIO ports. Each input channel gets:
- a synchroniser,
- a per-channel debouncer,
- rise/fall event detection with sticky, write-one-to-clear flags and a masked interrupt.

Outputs are registered, with optional global PWM dimming. It replaces ad-hoc switch/LED flops in board tops (Basys3, Nexys A7) with one reusable block.

## Interface
Parameters:
- `IN_W`, 16, number of input channels (switches/buttons)
- `OUT_W`, 16, number of output channels (LEDs)
- `SYNC_STAGES`, 2, synchroniser depth, legal 2..4
- `DEBOUNCE_CYC`, 250000, consecutive stable cycles required (10 ms at 25 MHz); 0 = bypass

Ports:
- `clk`  in  1  core clock
- `rstn`  in  1  reset, asynchronous assert, active-low
- `i_pin`  in  IN_W  raw asynchronous board inputs
- `o_in`  out  IN_W  debounced input level to core GPIO
- `o_rise`  out  IN_W  sticky rising-edge flags
- `o_fall`  out  IN_W  sticky falling-edge flags
- `i_evt_clr`  in  IN_W  one-cycle pulse; clears both rise and fall flags of each set bit
- `i_irq_mask`  in  IN_W  1 = channel enabled for interrupt
- `o_irq`  out  1  registered OR of (rise|fall) & mask
- `i_out`  in  OUT_W  core GPIO output value
- `i_duty`  in  8  global output brightness (PWM builds only)
- `o_pin`  out  OUT_W  registered board outputs

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per input, all reset to 0. Output is `sync`.
- **Debouncer (per channel):**
  - Holds `stable` (reset 0) and a counter of width clog2(DEBOUNCE_CYC+1) (reset 0).
  - `sync == stable` → counter cleared.
  - `sync != stable` → counter increments.
  - When the counter would reach DEBOUNCE_CYC, `stable` takes `sync` and the counter clears.
  - Any single-cycle return to equality restarts the count.
  - DEBOUNCE_CYC = 0: `stable <= sync` every cycle.
- **`o_in`:** equals `stable`.
- **Edge detect:**
  - `stable` 0→1 sets the rise flag; 1→0 sets the fall flag.
  - Flags hold until cleared by `i_evt_clr`.
  - Set and clear on the same channel in the same cycle: set wins.
- **IRQ:** `o_irq <= |((o_rise|o_fall) & i_irq_mask)`. Level-type; deasserts one cycle after the last enabled flag clears or its mask drops.
- **Reset exit with a pin held high:** a rise event is intentionally reported after sync + debounce latency.
- **Output path:** `o_pin <= i_out` (optionally gated by PWM).
- **Reset values:** every output is 0, including `o_pin` and `o_irq`.
- **`rstn` mid-debounce:** aborts the count; the channel restarts from `stable` = 0.

## Timing
- `i_pin` → `sync`: SYNC_STAGES cycles.
- `sync` change → `o_in`: DEBOUNCE_CYC cycles, provided `sync` holds; 1 cycle in bypass.
- `o_in` change → flag set: same cycle as `o_in` updates (flags register alongside `stable`).
- Flag → `o_irq`: +1 cycle.
- `i_evt_clr` → flag low: next edge.
- `i_out` → `o_pin`: 1 cycle (plus PWM gating).

## Configuration
`SWERVOLF_GPIO_PWM_EN`.

Defined:
- An 8-bit free-running counter `pwm_cnt` (reset 0) runs continuously.
- `o_pin <= i_out & {OUT_W{pwm_on}}`, where `pwm_on = (duty_q == 8'hFF) | (pwm_cnt < duty_q)`.
- `duty_q` (reset 8'hFF) samples `i_duty` only when `pwm_cnt == 8'hFF`, so no period is glitched.
- Duty 0 = off; duty 255 = fully on.

Undefined:
- No counter is built.
- `i_duty` is ignored.
- `o_pin <= i_out`.

## Structure
- **Package `swervolf_gpio_pkg`:** `DEBOUNCE_DEFAULT` (250000), `PWM_W` (8), and the localparam function for counter width.
- **Sub-module `swervolf_debounce`:**
  - Single channel: synchroniser, debouncer, edge flags.
  - Ports `clk`, `rstn`, `i_pin`, `i_clr`, `o_level`, `o_rise`, `o_fall`.
  - Instantiated IN_W times with a generate loop.
  - The top holds the IRQ reduction and output/PWM logic.

## Test plan
- **Bounce rejection:** DEBOUNCE_CYC=8, SYNC_STAGES=2, `i_pin[0]` toggles every 3 cycles for 30 cycles, then holds 1 → `o_in[0]` stays 0 during bouncing, rises exactly 2+8 cycles after the last toggle, and `o_rise[0]`=1 with `o_fall[0]`=0.
- **Clear/IRQ:**
  - `o_rise[3]` set, mask=16'h0008 → `o_irq`=1 one cycle later.
  - `i_evt_clr`=16'h0008 → flag 0 next cycle, `o_irq` 0 the cycle after.
  - Same stimulus with mask=0 → `o_irq` never rises.
- **Set/clear collision:** `i_evt_clr[5]` pulses in the same cycle `o_in[5]` falls → `o_fall[5]` remains 1.
- **Reset mid-count:** `i_pin[1]`=1, `rstn` pulsed low at count 5 of 8 → all outputs 0 immediately; `o_in[1]` rises 10 cycles after `rstn` release; `o_rise[1]`=1.
- **PWM (`SWERVOLF_GPIO_PWM_EN`):** `i_out`=16'hFFFF, `i_duty`=64 → `o_pin` high exactly 64 of every 256 cycles. Changing `i_duty` mid-period takes effect only after the next `pwm_cnt`=255. With the macro undefined, `o_pin`=16'hFFFF constantly.
- **Bypass:** DEBOUNCE_CYC=0 → `o_in` follows `i_pin` after 3 cycles, and every toggle sets a flag.

Source files
------------

// File: rtl/swervolf_gpio_pkg.sv
// swervolf_gpio_pkg: shared constants for the board GPIO front end.
// Optional feature macro used by this block: SWERVOLF_GPIO_PWM_EN.
package swervolf_gpio_pkg;

    localparam int DEBOUNCE_DEFAULT = 250000;
    localparam int PWM_W            = 8;

    // Debounce counter width: clog2(cyc+1), never narrower than one bit
    function automatic int cnt_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/swervolf_debounce.sv
// swervolf_debounce: one input channel -- synchroniser, debouncer and
// sticky rise/fall flags (set beats clear on a same-cycle collision).
module swervolf_debounce
    import swervolf_gpio_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_pin,
    input  logic i_clr,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;
    logic                   stable_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Shift the raw pin through the metastability chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            // No filtering: the stable level follows the synchroniser
            always_comb begin
                stable_d = sync;
            end
        end else begin : g_count
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count consecutive disagreeing cycles; accept on the last one
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (sync != stable_q) begin
                    if (cnt_q + ONE == LIMIT) begin
                        stable_d = sync;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end

            // Debounce counter register
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Flags are set from the level change being registered this cycle,
    // so they update together with the stable level
    always_comb begin
        rise_d = (stable_d & ~stable_q) | (rise_q & ~i_clr);
        fall_d = (~stable_d & stable_q) | (fall_q & ~i_clr);
    end

    // Stable level and sticky event flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign o_level = stable_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/swervolf_gpio_io.sv
// swervolf_gpio_io: board I/O front end -- debounced inputs with event
// flags and a masked IRQ, registered outputs. Macro: SWERVOLF_GPIO_PWM_EN.
module swervolf_gpio_io
    import swervolf_gpio_pkg::*;
#(
    parameter int IN_W         = 16,
    parameter int OUT_W        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IN_W-1:0]  i_pin,
    output logic [IN_W-1:0]  o_in,
    output logic [IN_W-1:0]  o_rise,
    output logic [IN_W-1:0]  o_fall,
    input  logic [IN_W-1:0]  i_evt_clr,
    input  logic [IN_W-1:0]  i_irq_mask,
    output logic             o_irq,
    input  logic [OUT_W-1:0] i_out,
    input  logic [PWM_W-1:0] i_duty,
    output logic [OUT_W-1:0] o_pin
);

    logic             irq_q;
    logic             irq_d;
    logic [OUT_W-1:0] pin_q;
    logic [OUT_W-1:0] pin_d;

    genvar g;
    generate
        for (g = 0; g < IN_W; g++) begin : g_ch
            swervolf_debounce #(
                .SYNC_STAGES  (SYNC_STAGES),
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_deb (
                .clk     (clk),
                .rstn    (rstn),
                .i_pin   (i_pin[g]),
                .i_clr   (i_evt_clr[g]),
                .o_level (o_in[g]),
                .o_rise  (o_rise[g]),
                .o_fall  (o_fall[g])
            );
        end
    endgenerate

    // Any pending, enabled event raises the level interrupt
    always_comb begin
        irq_d = |((o_rise | o_fall) & i_irq_mask);
    end

`ifdef SWERVOLF_GPIO_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] duty_q;
    logic             pwm_on;

    // Free-running period counter; duty only reloads at period end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt_q <= '0;
            duty_q    <= '1;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            if (pwm_cnt_q == '1) begin
                duty_q <= i_duty;
            end
        end
    end

    assign pwm_on = (duty_q == '1) | (pwm_cnt_q < duty_q);

    // Gate every output by the shared brightness phase
    always_comb begin
        pin_d = i_out & {OUT_W{pwm_on}};
    end
`else
    logic unused_duty;

    assign unused_duty = ^i_duty;

    // Outputs pass straight through to the pin register
    always_comb begin
        pin_d = i_out;
    end
`endif

    // Interrupt and board-output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q <= 1'b0;
            pin_q <= '0;
        end else begin
            irq_q <= irq_d;
            pin_q <= pin_d;
        end
    end

    assign o_irq = irq_q;
    assign o_pin = pin_q;

endmodule
